// File: rtl/door_pkg.sv
// Shared encodings for the garage door opener and its command sequencer.
package door_pkg;

  localparam logic [1:0] DOOR_CLOSED  = 2'b00;
  localparam logic [1:0] DOOR_OPENING = 2'b01;
  localparam logic [1:0] DOOR_OPEN    = 2'b10;
  localparam logic [1:0] DOOR_CLOSING = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam int REQ_WALL   = 0;
  localparam int REQ_KEYPAD = 1;
  localparam int REQ_REMOTE = 2;
  localparam int NUM_REQ    = 3;

  // Lowest index wins: wall > keypad > remote.
  function automatic logic [NUM_REQ-1:0] prio_pick(input logic [NUM_REQ-1:0] p);
    return p & (NUM_REQ'(~p) + NUM_REQ'(1));
  endfunction

endpackage

// File: rtl/door_cmd_sequencer_req_capture.sv
// Per-requester rising-edge detector with a sticky pending flag; a new edge beats a clear.
module req_capture (
  input  logic clk,
  input  logic r,
  input  logic req,
  input  logic clr,
  output logic pend
);

  logic prev;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= req;
      pend <= (req & ~prev) | (pend & ~clr);
    end
  end

endmodule

// File: rtl/door_cmd_sequencer.sv
// Arbitrates wall/keypad/remote (and optional auto-close) into spaced one-cycle button pulses.
// Optional feature: define DOOR_AUTO_CLOSE_EN to build the auto-close timer.
module door_cmd_sequencer
  import door_pkg::*;
#(
  parameter int AUTO_CLOSE_CYCLES = 1000,
  parameter int HOLDOFF_CYCLES    = 16,
  parameter int CNT_W             = 16
) (
  input  logic       clk,
  input  logic       r,
  input  logic [2:0] req,
  input  logic [1:0] door_state,
  input  logic       s,
  output logic       b,
  output logic [2:0] grant,
  output logic       busy,
  output logic       ac_pending
);

  logic [NUM_REQ-1:0] pend, clr, win;
  logic [1:0]         state;
  logic [CNT_W-1:0]   ho_cnt;
  logic               auto_flag;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cap
      req_capture u_cap (
        .clk  (clk),
        .r    (r),
        .req  (req[i]),
        .clr  (clr[i]),
        .pend (pend[i])
      );
    end
  endgenerate

  assign win  = prio_pick(pend);
  // Winner is retired on the edge that launches its pulse.
  assign clr  = (state == ST_IDLE) ? win : '0;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state  <= ST_IDLE;
      b      <= 1'b0;
      grant  <= '0;
      ho_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((|pend) || auto_flag) begin
            state <= ST_PULSE;
            b     <= 1'b1;
            grant <= win;
          end
        end
        ST_PULSE: begin
          state  <= ST_HOLDOFF;
          b      <= 1'b0;
          grant  <= '0;
          ho_cnt <= '0;
        end
        ST_HOLDOFF: begin
          if (ho_cnt == CNT_W'(HOLDOFF_CYCLES - 1)) state <= ST_IDLE;
          else                                       ho_cnt <= ho_cnt + 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          b     <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef DOOR_AUTO_CLOSE_EN
  logic [CNT_W-1:0] ac_cnt;
  logic             ac_ok, quiet;

  assign ac_ok      = (door_state == DOOR_OPEN) && !s;
  assign quiet      = (state == ST_IDLE) && (pend == '0);
  assign ac_pending = (ac_cnt != '0);

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      ac_cnt    <= '0;
      auto_flag <= 1'b0;
    end else if (!ac_ok) begin
      ac_cnt    <= '0;
      auto_flag <= 1'b0;
    end else if (quiet && auto_flag) begin
      // Granted this edge: nothing outranks it once the req flags are empty.
      auto_flag <= 1'b0;
    end else if (quiet) begin
      if (ac_cnt == CNT_W'(AUTO_CLOSE_CYCLES - 1)) begin
        auto_flag <= 1'b1;
        ac_cnt    <= '0;
      end else begin
        ac_cnt <= ac_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_ac;
  assign unused_ac  = ^{door_state, s, (AUTO_CLOSE_CYCLES > 0)};
  assign auto_flag  = 1'b0;
  assign ac_pending = 1'b0;
`endif

endmodule

// File: tb/tb_door_cmd_sequencer.sv
// Directed bench for door_cmd_sequencer (HOLDOFF=4, AUTO_CLOSE=8).
module tb_door_cmd_sequencer;

  logic       clk = 1'b0;
  logic       r;
  logic [2:0] req;
  logic [1:0] door_state;
  logic       s;
  logic       b;
  logic [2:0] grant;
  logic       busy;
  logic       ac_pending;

  int checks = 0;
  int errors = 0;

  door_cmd_sequencer #(
    .AUTO_CLOSE_CYCLES (8),
    .HOLDOFF_CYCLES    (4),
    .CNT_W             (16)
  ) dut (
    .clk        (clk),
    .r          (r),
    .req        (req),
    .door_state (door_state),
    .s          (s),
    .b          (b),
    .grant      (grant),
    .busy       (busy),
    .ac_pending (ac_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, ending on the following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_count(input int n, output int pulses, output logic [2:0] lastg,
                           output int acseen);
    pulses = 0;
    lastg  = '0;
    acseen = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (b) begin
        pulses++;
        lastg = grant;
      end
      if (ac_pending) acseen++;
    end
  endtask

  int         np, nac;
  logic [2:0] g;

  initial begin
    r = 1'b1; req = '0; door_state = 2'b00; s = 1'b0;
    #12;
    check("rst_b", b, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_acp", ac_pending, 0);
    @(negedge clk); r = 1'b0;
    step(2);

    // Single wall press held for several cycles
    req = 3'b001;
    step(1); check("wall_lat1_b", b, 0);
    step(1); check("wall_b", b, 1); check("wall_grant", grant, 3'b001); check("wall_busy", busy, 1);
    step(1); check("wall_width", b, 0); check("wall_hold_busy", busy, 1);
    step(3); req = 3'b000;
    run_count(10, np, g, nac);
    check("wall_no_repeat", np, 0);
    check("wall_idle_busy", busy, 0);

    // Simultaneous edges on all three requesters
    req = 3'b111;
    step(1); req = 3'b000; check("all_lat1_b", b, 0);
    step(1); check("all_p1_b", b, 1); check("all_p1_grant", grant, 3'b001);
    step(5); check("all_gap_b", b, 0);
    step(1); check("all_p2_b", b, 1); check("all_p2_grant", grant, 3'b010);
    step(6); check("all_p3_b", b, 1); check("all_p3_grant", grant, 3'b100);
    run_count(10, np, g, nac);
    check("all_no_extra", np, 0);

    // Two remote presses during a hold-off merge into one pulse
    req = 3'b001;
    step(2); check("merge_wall_grant", grant, 3'b001);
    req = 3'b000;
    req = 3'b100; step(1);
    req = 3'b000; step(1);
    req = 3'b100; step(1);
    req = 3'b000;
    run_count(15, np, g, nac);
    check("merge_pulses", np, 1);
    check("merge_grant", g, 3'b100);

    // Async reset in the middle of a pulse
    req = 3'b011;
    step(2); check("rstmid_pre_b", b, 1); check("rstmid_pre_grant", grant, 3'b001);
    req = 3'b000;
    #2 r = 1'b1;
    #1;
    check("rstmid_b", b, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_grant", grant, 0);
    @(negedge clk); r = 1'b0;
    run_count(15, np, g, nac);
    check("rstmid_no_replay", np, 0);

`ifdef DOOR_AUTO_CLOSE_EN
    // Auto-close fires after AUTO_CLOSE_CYCLES quiet open cycles
    door_state = 2'b10; s = 1'b0;
    step(7); check("ac_running", ac_pending, 1); check("ac_early_b", b, 0);
    step(1); check("ac_fire_b", b, 0); check("ac_clear_cnt", ac_pending, 0);
    step(1); check("ac_b", b, 1); check("ac_grant", grant, 3'b000);
    door_state = 2'b11;
    step(8);
    // Obstruction cancels the countdown
    door_state = 2'b10;
    step(5); check("ac_obs_pre", ac_pending, 1);
    s = 1'b1;
    step(1); check("ac_obs_clr", ac_pending, 0);
    run_count(12, np, g, nac);
    check("ac_obs_pulses", np, 0);
    check("ac_obs_cnt", nac, 0);
    s = 1'b0; door_state = 2'b00;
`else
    // Door left open with no timer built: nothing happens
    door_state = 2'b10; s = 1'b0;
    run_count(16, np, g, nac);
    check("noac_pulses", np, 0);
    check("noac_acp", nac, 0);
    door_state = 2'b00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
